button_conditioner: RTL and testbench

Front-end conditioning stage for the four user pushbuttons that drive the parameter selector. Each raw button input is synchronized to `clk_65mhz`, debounced with a per-channel counter, and converted into a single-cycle press pulse on `up`, `down`, `next` and `set`. An optional hold-to-repeat feature on `up` and `down` lets the user scroll through values by holding a button. Outputs connect directly to the selector's `up`/`down`/`next`/`set` inputs.

---
 rtl/button_conditioner.sv | 121 ++++++++++++
 tb/tb_button_conditioner.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Synchronizes, debounces and edge-detects the four user pushbuttons into press pulses.
// Define BUTTON_REPEAT_EN to add hold-to-repeat on the up and down channels.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 650000,
    parameter int REPEAT_DELAY    = 32500000,
    parameter int REPEAT_PERIOD   = 6500000
) (
    input  logic       clk_65mhz,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    output logic [3:0] btn_level,
    output logic       up,
    output logic       down,
    output logic       next,
    output logic       set
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("button_conditioner: invalid timing parameters");
    end

    logic [3:0]    s1;
    logic [3:0]    s2;
    logic [3:0]    stb;
    logic [CW-1:0] cnt [4];
    logic [3:0]    flip;
    logic [3:0]    press;
    logic [1:0]    rep;

    // flip marks the edge on which the stable level changes
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            flip[i] = (s2[i] != stb[i]) && (cnt[i] == CNT_LAST);
        end
    end

    assign press     = flip & ~stb;
    assign btn_level = stb;

    always_ff @(posedge clk_65mhz) begin
        if (rst) begin
            s1  <= '0;
            s2  <= '0;
            stb <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == stb[i]) begin
                    cnt[i] <= '0;
                end else if (flip[i]) begin
                    stb[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

`ifdef BUTTON_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] hcnt [2];
    logic [1:0]    in_period;

    // a channel releasing on this edge must not fire a repeat on the same edge
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rep[i] = stb[i] && !flip[i] &&
                     (hcnt[i] == (in_period[i] ? PERIOD_LAST : DELAY_LAST));
        end
    end

    always_ff @(posedge clk_65mhz) begin
        if (rst) begin
            in_period <= '0;
            for (int i = 0; i < 2; i++) begin
                hcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!stb[i] || flip[i]) begin
                    hcnt[i]      <= '0;
                    in_period[i] <= 1'b0;
                end else if (rep[i]) begin
                    hcnt[i]      <= '0;
                    in_period[i] <= 1'b1;
                end else begin
                    hcnt[i] <= hcnt[i] + RW'(1);
                end
            end
        end
    end
`else
    assign rep = '0;
`endif

    always_ff @(posedge clk_65mhz) begin
        if (rst) begin
            up   <= 1'b0;
            down <= 1'b0;
            next <= 1'b0;
            set  <= 1'b0;
        end else begin
            up   <= press[0] | rep[0];
            down <= press[1] | rep[1];
            next <= press[2];
            set  <= press[3];
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: expected pulse cycles are queued per channel when stimulus
// is driven and matched against each observed pulse; levels are checked from a vector table.
module tb_button_conditioner;
    localparam int D   = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;
    localparam int LAT = D + 2;   // drive-after-edge c  ->  pulse after edge c+LAT

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic       up, down, next, set;

    int   cyc   = 0;
    logic rst_q = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_next = 0;
    int   n0;
    int   p;
    int   q_up[$], q_down[$], q_next[$], q_set[$];

    typedef struct {
        logic [3:0] raw;
        int         hold;
        logic [3:0] level;
    } vec_t;

    vec_t       vecs[8];
    logic [3:0] prev_level;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk_65mhz(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .up(up),
        .down(down),
        .next(next),
        .set(set)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_pulse(input int ch, input int t);
        case (ch)
            0: q_up.push_back(t);
            1: q_down.push_back(t);
            2: q_next.push_back(t);
            default: q_set.push_back(t);
        endcase
    endtask

    task automatic got_pulse(input int ch);
        int t;
        bit ok;
        ok = 1'b0;
        t  = 0;
        case (ch)
            0: if (q_up.size() > 0)   begin t = q_up.pop_front();   ok = 1'b1; end
            1: if (q_down.size() > 0) begin t = q_down.pop_front(); ok = 1'b1; end
            2: if (q_next.size() > 0) begin t = q_next.pop_front(); ok = 1'b1; end
            default: if (q_set.size() > 0) begin t = q_set.pop_front(); ok = 1'b1; end
        endcase
        if (ok) begin
            check($sformatf("pulse_ch%0d_cycle", ch), cyc, t);
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL pulse_ch%0d_unexpected: got pulse at cycle %0d, expected none", ch, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (rst_q) check("reset_outputs", int'({btn_level, up, down, next, set}), 0);
            if (up)   got_pulse(0);
            if (down) got_pulse(1);
            if (next) begin
                got_pulse(2);
                n_next++;
            end
            if (set)  got_pulse(3);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{4'b0100, 10, 4'b0100};
        vecs[1] = '{4'b1100, 10, 4'b1100};
        vecs[2] = '{4'b1000, 10, 4'b1000};
        vecs[3] = '{4'b1010, 10, 4'b1010};
        vecs[4] = '{4'b0001,  3, 4'b1010};   // 3-cycle glitch on up, others still high
        vecs[5] = '{4'b0000, 10, 4'b0000};
        vecs[6] = '{4'b1111, 10, 4'b1111};
        vecs[7] = '{4'b0000, 10, 4'b0000};

        // buttons held through reset
        rst     = 1'b1;
        btn_raw = 4'hF;
        step(3);
        rst = 1'b0;
        for (int ch = 0; ch < 4; ch++) expect_pulse(ch, cyc + LAT);
        step(10);
        check("reset_held_level", int'(btn_level), 15);
        btn_raw = 4'h0;
        step(10);
        check("reset_released_level", int'(btn_level), 0);

        // bounce rejection on next
        n0 = n_next;
        for (int i = 0; i < 4; i++) begin
            btn_raw[2] = (i % 2 == 0) ? 1'b1 : 1'b0;
            step(2);
        end
        btn_raw[2] = 1'b1;
        expect_pulse(2, cyc + LAT);
        step(12);
        btn_raw[2] = 1'b0;
        step(10);
        check("bounce_next_count", n_next - n0, 1);

        // clean press and release on set
        btn_raw[3] = 1'b1;
        expect_pulse(3, cyc + LAT);
        step(30);
        btn_raw[3] = 1'b0;
        step(D + 1);
        check("release_level_still_high", int'(btn_level[3]), 1);
        step(1);
        check("release_level_fell", int'(btn_level[3]), 0);
        step(10);

        // simultaneous press
        btn_raw = 4'b0011;
        expect_pulse(0, cyc + LAT);
        expect_pulse(1, cyc + LAT);
        step(10);
        btn_raw = 4'b0000;
        step(10);

        // level vector table
        prev_level = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            btn_raw = vecs[i].raw;
            for (int b = 0; b < 4; b++) begin
                if (vecs[i].level[b] && !prev_level[b]) expect_pulse(b, cyc + LAT);
            end
            step(vecs[i].hold);
            check($sformatf("vec%0d_level", i), int'(btn_level), int'(vecs[i].level));
            prev_level = vecs[i].level;
        end
        step(10);

        // hold up: stable level stays high for 60 cycles after the press pulse
        btn_raw[0] = 1'b1;
        p = cyc + LAT;
        expect_pulse(0, p);
`ifdef BUTTON_REPEAT_EN
        expect_pulse(0, p + RD);
        for (int k = 1; k <= 4; k++) expect_pulse(0, p + RD + k * RP);
`endif
        step(LAT + 54);
        btn_raw[0] = 1'b0;
        step(40);
        check("hold_release_level", int'(btn_level[0]), 0);

        // reset in the middle of a debounce
        btn_raw[1] = 1'b1;
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        expect_pulse(1, cyc + LAT);
        step(12);
        check("mid_reset_level", int'(btn_level[1]), 1);
        btn_raw = 4'h0;
        step(12);

        check("pending_up",   q_up.size(),   0);
        check("pending_down", q_down.size(), 0);
        check("pending_next", q_next.size(), 0);
        check("pending_set",  q_set.size(),  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
